// File: rtl/pc_fetch_unit_if.sv
// CU-facing bundle for the PC/fetch stage: CU strobes, the CODE bus and the fetch registers.
// The master side (CU/memory) drives the strobes and data; the slave side (fetch unit) drives the registers.
interface pc_fetch_unit_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              Phase;
  logic [2:0]        PC_CON;
  logic              IR_en;
  logic              rel_en;
  logic              ALE;
  logic [ADDR_W-1:0] jmp_addr;
  logic [7:0]        code_data;
  logic [ADDR_W-1:0] code_addr;
  logic [ADDR_W-1:0] PC;
  logic [7:0]        IR;
  logic [7:0]        rel;

  modport master (
    output Phase, PC_CON, IR_en, rel_en, ALE, jmp_addr, code_data,
    input  code_addr, PC, IR, rel
  );

  modport slave (
    input  Phase, PC_CON, IR_en, rel_en, ALE, jmp_addr, code_data,
    output code_addr, PC, IR, rel
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter, IR and rel registers behind the control unit, plus the ALE-driven CODE address latch.
// Every output is a register; PC/IR/rel move only on Phase2 edges, the ALE latch runs on every edge.
module pc_fetch_unit #(
  parameter int unsigned      ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [7:0]        IR_RESET = 8'h00
) (
  input  logic           clk,
  input  logic           reset,
  pc_fetch_unit_if.slave bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned EXT_W  = ADDR_W - BYTE_W;

  typedef enum logic {
    ALE_IDLE = 1'b0,
    ALE_HIGH = 1'b1
  } ale_state_e;

  ale_state_e        r_ale_q;
  ale_state_e        w_ale_next;
  logic              w_capture;

  logic              r_rst_done;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_code_addr;
  logic [BYTE_W-1:0] r_ir;
  logic [BYTE_W-1:0] r_rel;

  logic              w_upd;
  logic              w_pc_en;
  logic              w_jump;
  logic              w_add_rel;
  logic [ADDR_W-1:0] w_rel_sext;
  logic [ADDR_W-1:0] w_pc_next;

  assign w_pc_en    = bus.PC_CON[2];
  assign w_jump     = bus.PC_CON[1];
  assign w_add_rel  = bus.PC_CON[0];
  // First edge after reset release is never an update edge.
  assign w_upd      = bus.Phase & r_rst_done;
  assign w_rel_sext = {{EXT_W{r_rel[BYTE_W-1]}}, r_rel};

  // PC next-state, first match wins; relative jumps use the pre-edge rel.
  always_comb begin
    w_pc_next = r_pc;
    if (w_jump && w_add_rel) begin
      w_pc_next = r_pc + ADDR_W'(w_pc_en) + w_rel_sext;
    end else if (w_jump) begin
      w_pc_next = bus.jmp_addr;
    end else if (w_pc_en) begin
      w_pc_next = r_pc + ADDR_W'(1);
    end
  end

  // ALE edge detector state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ale_q <= ALE_IDLE;
    end else begin
      r_ale_q <= w_ale_next;
    end
  end

  // ALE next-state; a capture is requested only on the high-to-low transition.
  always_comb begin
    w_ale_next = r_ale_q;
    w_capture  = 1'b0;
    case (r_ale_q)
      ALE_IDLE: begin
        if (bus.ALE) begin
          w_ale_next = ALE_HIGH;
        end
      end
      ALE_HIGH: begin
        if (!bus.ALE) begin
          w_ale_next = ALE_IDLE;
          w_capture  = 1'b1;
        end
      end
      default: begin
        w_ale_next = ALE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_done  <= 1'b0;
      r_pc        <= RESET_PC;
      r_code_addr <= RESET_PC;
      r_ir        <= IR_RESET;
      r_rel       <= '0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_upd) begin
        r_pc <= w_pc_next;
        if (bus.IR_en) begin
          r_ir <= bus.code_data;
        end
        if (bus.rel_en) begin
          r_rel <= bus.code_data;
        end
      end
      // Latch the PC as it stood before this edge's update.
      if (w_capture) begin
        r_code_addr <= r_pc;
      end
    end
  end

  assign bus.PC        = r_pc;
  assign bus.code_addr = r_code_addr;
  assign bus.IR        = r_ir;
  assign bus.rel       = r_rel;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: hand-computed expectations checked with immediate assertions.
module tb_pc_fetch_unit;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  pc_fetch_unit_if #(.ADDR_W(16)) bus ();

  pc_fetch_unit #(
    .ADDR_W  (16),
    .RESET_PC(16'h0000),
    .IR_RESET(8'h00)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Phase     = 1'b0;
    bus.PC_CON    = 3'b000;
    bus.IR_en     = 1'b0;
    bus.rel_en    = 1'b0;
    bus.ALE       = 1'b0;
    bus.jmp_addr  = 16'h0000;
    bus.code_data = 8'h00;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One Phase2 edge performing an absolute jump.
  task automatic jump_to(input logic [15:0] target);
    bus.Phase    = 1'b1;
    bus.PC_CON   = 3'b010;
    bus.jmp_addr = target;
    tick();
    bus.PC_CON   = 3'b000;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    chk16("rst_pc", bus.PC, 16'h0000);
    chk16("rst_caddr", bus.code_addr, 16'h0000);
    chk8("rst_ir", bus.IR, 8'h00);
    chk8("rst_rel", bus.rel, 8'h00);
    reset = 1'b1;
    tick();

    // T1: load state, then async reset mid-cycle
    bus.IR_en     = 1'b1;
    bus.rel_en    = 1'b1;
    bus.code_data = 8'h5A;
    jump_to(16'h1234);
    bus.IR_en  = 1'b0;
    bus.rel_en = 1'b0;
    chk16("t1_jump", bus.PC, 16'h1234);
    chk8("t1_ir_load", bus.IR, 8'h5A);
    chk8("t1_rel_load", bus.rel, 8'h5A);
    bus.Phase = 1'b0;
    bus.ALE   = 1'b1;
    tick();
    bus.ALE = 1'b0;
    tick();
    chk16("t1_caddr", bus.code_addr, 16'h1234);
    #2 reset = 1'b0;
    #1;
    chk16("t1_rst_pc", bus.PC, 16'h0000);
    chk16("t1_rst_caddr", bus.code_addr, 16'h0000);
    chk8("t1_rst_ir", bus.IR, 8'h00);
    chk8("t1_rst_rel", bus.rel, 8'h00);
    tick();
    reset = 1'b1;
    bus.Phase  = 1'b1;
    bus.PC_CON = 3'b100;
    tick();
    chk16("first_edge_no_upd", bus.PC, 16'h0000);

    // T2: sequential fetch and wrap
    jump_to(16'h00FF);
    bus.PC_CON = 3'b100;
    tick();
    tick();
    tick();
    chk16("t2_seq", bus.PC, 16'h0102);
    jump_to(16'hFFFF);
    bus.PC_CON = 3'b100;
    tick();
    chk16("t2_wrap", bus.PC, 16'h0000);

    // T3: SJMP back with rel = -2
    bus.rel_en    = 1'b1;
    bus.code_data = 8'hFE;
    jump_to(16'h0010);
    bus.rel_en = 1'b0;
    bus.PC_CON = 3'b111;
    tick();
    chk16("t3_rel_pcen", bus.PC, 16'h000F);
    jump_to(16'h0010);
    bus.PC_CON = 3'b011;
    tick();
    chk16("t3_rel", bus.PC, 16'h000E);

    // T4: relative jump uses old rel while rel reloads
    bus.rel_en    = 1'b1;
    bus.code_data = 8'h05;
    jump_to(16'h0100);
    chk8("t4_rel_pre", bus.rel, 8'h05);
    bus.code_data = 8'h80;
    bus.PC_CON    = 3'b011;
    tick();
    bus.rel_en = 1'b0;
    bus.PC_CON = 3'b000;
    chk16("t4_pc", bus.PC, 16'h0105);
    chk8("t4_rel_new", bus.rel, 8'h80);

    // T5: Phase gating
    bus.Phase     = 1'b0;
    bus.IR_en     = 1'b1;
    bus.PC_CON    = 3'b100;
    bus.code_data = 8'hE5;
    tick();
    chk16("t5_gate_pc", bus.PC, 16'h0105);
    chk8("t5_gate_ir", bus.IR, 8'h00);
    bus.Phase = 1'b1;
    tick();
    bus.IR_en  = 1'b0;
    bus.PC_CON = 3'b000;
    chk16("t5_upd_pc", bus.PC, 16'h0106);
    chk8("t5_upd_ir", bus.IR, 8'hE5);

    // Negative rel (-128) past zero wraps
    jump_to(16'h0005);
    bus.PC_CON = 3'b011;
    tick();
    bus.PC_CON = 3'b000;
    chk16("neg_rel_wrap", bus.PC, 16'hFF85);

    // T6: ALE capture on the fall, with same-edge PC increment
    jump_to(16'h0200);
    bus.ALE = 1'b1;
    tick();
    tick();
    bus.ALE    = 1'b0;
    bus.PC_CON = 3'b100;
    tick();
    chk16("t6_caddr", bus.code_addr, 16'h0200);
    chk16("t6_pc", bus.PC, 16'h0201);
    bus.ALE = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk16("t6_held_caddr", bus.code_addr, 16'h0200);
    chk16("t6_held_pc", bus.PC, 16'h020B);
    bus.ALE = 1'b0;
    tick();
    chk16("t6_fall_caddr", bus.code_addr, 16'h020B);
    chk16("t6_fall_pc", bus.PC, 16'h020C);
    bus.PC_CON = 3'b000;

    // Reset released while ALE is high: latch only after a later fall
    bus.ALE = 1'b1;
    reset   = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    jump_to(16'h0300);
    tick();
    chk16("ale_rst_hold", bus.code_addr, 16'h0000);
    bus.ALE = 1'b0;
    tick();
    chk16("ale_rst_fall", bus.code_addr, 16'h0300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
